// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   ADDR_W / INSTR_W   : word-address and instruction widths
//   HALT_INSTR_DEF     : default encoding that stops sequential fetch
//   fetch_state_e      : fetch FSM states
//   fetch_entry_t      : one fetch-buffer entry {pc, instr}
package instruction_fetch_unit_pkg;
  localparam int ADDR_W  = 48;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] HALT_INSTR_DEF = 32'h0000_0073;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    STALL  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// fetch_buffer: 2-entry in-order FIFO of {pc, instr}.
//   clk, rst_n : clock, async active-low reset (clears count and storage)
//   push       : enqueue push_data
//   pop        : dequeue head
//   flush      : drop everything (wins over push/pop)
//   count      : occupancy 0..2
//   head       : registered head entry (slot0)
// Callers never push when full without popping in the same cycle,
// and never pop when empty.
module fetch_buffer
  import instruction_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);
  fetch_entry_t slot0, slot1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; shift when full so order is preserved.
          if (count == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = slot0;
endmodule

// File: rtl/instruction_memory.sv
// instruction_memory: 64-word instruction store with a synchronous write
// port for loading and a combinational read port.
//   clk          : write clock
//   we/waddr/wdata : write port
//   addr/rdata   : combinational read (low word-address bits)
module instruction_memory (
  input  logic        clk,
  input  logic        we,
  input  logic [5:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [5:0]  addr,
  output logic [31:0] rdata
);
  logic [31:0] mem [0:63];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: sequential instruction fetch into a 2-entry
// buffer, with redirect, backpressure stall and halt-on-instruction.
//   clk, rst_n        : clock, async active-low reset
//   imem_addr         : word address to instruction memory (= pc)
//   imem_instr        : combinational memory read data for imem_addr
//   redirect_valid/target : branch/jump; flushes and reloads pc
//   out_valid/instr/pc    : buffer head toward decode
//   out_ready         : decode accepts head
//   halted            : fetch stopped after a HALT_INSTR was enqueued
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [47:0] RESET_PC   = 48'h0,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [47:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [47:0] redirect_target,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [47:0] out_pc,
  input  logic        out_ready,
  output logic        halted
);
  logic [ADDR_W-1:0] pc;
  fetch_state_e      state;
  logic [1:0]        count;
  fetch_entry_t      head, push_data;
  logic              pop, push, can_push;

  assign imem_addr = pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign halted    = (state == HALTED);

  // Redirect suppresses both sides of the buffer for its cycle.
  assign pop      = out_valid && out_ready && !redirect_valid;
  assign can_push = (count != 2'd2) || pop;
  assign push     = !redirect_valid && (state != HALTED) && can_push;

  assign push_data.pc    = pc;
  assign push_data.instr = imem_instr;

  fetch_buffer u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      state <= FETCH;
    end else if (redirect_valid) begin
      pc    <= redirect_target;
      state <= FETCH;
    end else if (push) begin
      // Natural 48-bit wrap.
      pc    <= pc + 48'd1;
      state <= (imem_instr == HALT_INSTR) ? HALTED : FETCH;
    end else if (state != HALTED) begin
      // Not halted and no push means full with no pop.
      state <= STALL;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam logic [47:0] RST_PC = 48'h0;
  localparam logic [31:0] HALT   = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [47:0] redirect_target;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [47:0] out_pc;
  logic        out_ready;
  logic        halted;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_wdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(RST_PC), .HALT_INSTR(HALT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_ready       (out_ready),
    .halted          (halted)
  );

  instruction_memory u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .addr  (imem_addr[5:0]),
    .rdata (imem_instr)
  );

  // Memory image: distinct words, none equal to HALT.
  function automatic logic [31:0] mw(input logic [47:0] a);
    return {16'hC0DE, 10'h0, a[5:0]};
  endfunction

  task automatic mem_write(input logic [5:0] a, input logic [31:0] d);
    mem_we = 1'b1; mem_waddr = a; mem_wdata = d;
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic enter_reset();
    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic release_reset(input logic rdy);
    rst_n = 1'b1; out_ready = rdy;
  endtask

  task automatic test_reset();
    enter_reset();
    for (int i = 0; i < 64; i++) mem_write(6'(i), mw(48'(i)));
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    if (out_pc !== 48'h0) begin failures++; $display("FAIL reset_pc got %h exp 0", out_pc); end
    if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got %h exp 0", out_instr); end
    if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got %b exp 0", halted); end
    if (imem_addr !== RST_PC) begin failures++; $display("FAIL reset_addr got %h exp %h", imem_addr, RST_PC); end
  endtask

  task automatic test_stream();
    enter_reset();
    release_reset(1'b1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid k=%0d got %b exp 1", k, out_valid); end
      if (out_pc !== 48'(k)) begin failures++; $display("FAIL stream_pc k=%0d got %h exp %h", k, out_pc, 48'(k)); end
      if (out_instr !== mw(48'(k))) begin failures++; $display("FAIL stream_instr k=%0d got %h exp %h", k, out_instr, mw(48'(k))); end
    end
  endtask

  task automatic test_stall();
    enter_reset();
    release_reset(1'b0);
    repeat (5) @(negedge clk);
    checks += 4;
    if (dut.u_buf.count !== 2'd2) begin failures++; $display("FAIL stall_count got %0d exp 2", dut.u_buf.count); end
    if (dut.state !== STALL) begin failures++; $display("FAIL stall_state got %0d exp %0d", dut.state, STALL); end
    if (imem_addr !== 48'd2) begin failures++; $display("FAIL stall_addr got %h exp 2", imem_addr); end
    if (out_pc !== 48'd0) begin failures++; $display("FAIL stall_head got %h exp 0", out_pc); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL drain_valid k=%0d got %b exp 1", k, out_valid); end
      if (out_pc !== 48'(k)) begin failures++; $display("FAIL drain_pc k=%0d got %h exp %h", k, out_pc, 48'(k)); end
      if (out_instr !== mw(48'(k))) begin failures++; $display("FAIL drain_instr k=%0d got %h exp %h", k, out_instr, mw(48'(k))); end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    enter_reset();
    release_reset(1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (dut.u_buf.count !== 2'd2) begin failures++; $display("FAIL redir_pre_count got %0d exp 2", dut.u_buf.count); end
    redirect_valid = 1'b1; redirect_target = 48'h000A;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got %b exp 0", out_valid); end
    if (imem_addr !== 48'hA) begin failures++; $display("FAIL redir_addr got %h exp a", imem_addr); end
    out_ready = 1'b1;
    for (int k = 10; k < 12; k++) begin
      @(negedge clk);
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL redir_valid k=%0d got %b exp 1", k, out_valid); end
      if (out_pc !== 48'(k)) begin failures++; $display("FAIL redir_pc k=%0d got %h exp %h", k, out_pc, 48'(k)); end
      if (out_instr !== mw(48'(k))) begin failures++; $display("FAIL redir_instr k=%0d got %h exp %h", k, out_instr, mw(48'(k))); end
    end
  endtask

  task automatic test_halt();
    enter_reset();
    mem_write(6'd5, HALT);
    release_reset(1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks += 2;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL halt_valid k=%0d got %b exp 1", k, out_valid); end
      if (out_pc !== 48'(k)) begin failures++; $display("FAIL halt_pc k=%0d got %h exp %h", k, out_pc, 48'(k)); end
    end
    checks += 2;
    if (out_instr !== HALT) begin failures++; $display("FAIL halt_instr got %h exp %h", out_instr, HALT); end
    if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag got %b exp 1", halted); end
    repeat (3) begin
      @(negedge clk);
      checks += 3;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL halted_valid got %b exp 0", out_valid); end
      if (imem_addr !== 48'd6) begin failures++; $display("FAIL halted_addr got %h exp 6", imem_addr); end
      if (halted !== 1'b1) begin failures++; $display("FAIL halted_hold got %b exp 1", halted); end
    end
    redirect_valid = 1'b1; redirect_target = 48'h0;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks += 2;
    if (halted !== 1'b0) begin failures++; $display("FAIL resume_halted got %b exp 0", halted); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL resume_empty got %b exp 0", out_valid); end
    @(negedge clk);
    checks += 2;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL resume_valid got %b exp 1", out_valid); end
    if (out_pc !== 48'd0) begin failures++; $display("FAIL resume_pc got %h exp 0", out_pc); end
    enter_reset();
    mem_write(6'd5, mw(48'd5));
  endtask

  task automatic test_wrap();
    enter_reset();
    release_reset(1'b1);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_target = 48'hFFFF_FFFF_FFFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL wrap_flush got %b exp 0", out_valid); end
    @(negedge clk);
    checks += 2;
    if (out_pc !== 48'hFFFF_FFFF_FFFF) begin failures++; $display("FAIL wrap_top_pc got %h exp ffffffffffff", out_pc); end
    if (out_instr !== mw(48'd63)) begin failures++; $display("FAIL wrap_top_instr got %h exp %h", out_instr, mw(48'd63)); end
    @(negedge clk);
    checks += 2;
    if (out_pc !== 48'd0) begin failures++; $display("FAIL wrap_zero_pc got %h exp 0", out_pc); end
    if (out_instr !== mw(48'd0)) begin failures++; $display("FAIL wrap_zero_instr got %h exp %h", out_instr, mw(48'd0)); end
  endtask

  task automatic test_reset_mid();
    enter_reset();
    release_reset(1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (dut.u_buf.count !== 2'd2) begin failures++; $display("FAIL mid_pre_count got %0d exp 2", dut.u_buf.count); end
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    if (out_pc !== 48'd0) begin failures++; $display("FAIL mid_pc got %h exp 0", out_pc); end
    if (imem_addr !== RST_PC) begin failures++; $display("FAIL mid_addr got %h exp %h", imem_addr, RST_PC); end
    @(negedge clk);
    release_reset(1'b1);
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL restart_valid got %b exp 1", out_valid); end
    if (out_pc !== RST_PC) begin failures++; $display("FAIL restart_pc got %h exp %h", out_pc, RST_PC); end
    if (out_instr !== mw(RST_PC)) begin failures++; $display("FAIL restart_instr got %h exp %h", out_instr, mw(RST_PC)); end
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 48'h0;
    mem_we = 1'b0; mem_waddr = 6'd0; mem_wdata = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
